// File: rtl/step_seq.sv
// Arithmetic-sequence source: takes a start value and beat count, then emits
// start+step, start+2*step, ... modulo 2^width, one beat per downstream handshake.
module step_seq #(
  parameter int width = 8,
  parameter int step  = 1,
  parameter int lenw  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in,
  input  logic [lenw-1:0]  len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out,
  output logic             last,
  output logic             carry,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [width-1:0] STEP_T = width'(step);

  // Sum carried at width+1 bits: low bits are the beat value, MSB is the carry.
  function automatic logic [width:0] add_step(input logic [width-1:0] a);
    return {1'b0, a} + {1'b0, STEP_T};
  endfunction

  state_t            state_q, state_d;
  logic [width-1:0]  out_q, out_d;
  logic              carry_q, carry_d;
  logic              last_q, last_d;
  logic              vld_q, vld_d;
  logic [lenw-1:0]   rem_q, rem_d;
  logic [width:0]    sum_in, sum_out;

  assign sum_in  = add_step(in);
  assign sum_out = add_step(out_q);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    last_d  = last_q;
    vld_d   = vld_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        // A zero-length request is consumed without leaving IDLE.
        if (in_valid && (len != '0)) begin
          out_d   = sum_in[width-1:0];
          carry_d = sum_in[width];
          rem_d   = len;
          vld_d   = 1'b1;
          last_d  = (len == lenw'(1));
          state_d = RUN;
        end
      end
      RUN: begin
        if (vld_q && out_ready) begin
          if (rem_q > lenw'(1)) begin
            out_d   = sum_out[width-1:0];
            carry_d = sum_out[width];
            rem_d   = rem_q - lenw'(1);
            last_d  = (rem_q == lenw'(2));
          end else begin
            // Final beat taken: out keeps its last value.
            vld_d   = 1'b0;
            last_d  = 1'b0;
            carry_d = 1'b0;
            rem_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = vld_q;
  assign out       = out_q;
  assign last      = last_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_step_seq.sv
// Scoreboard bench for step_seq: width=8/step=3 instance plus a width=4/step=7 override.
module tb_step_seq;

  localparam int W    = 8;
  localparam int STEP = 3;

  typedef struct packed {
    logic [7:0] v;
    logic       c;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, last, carry, busy;
  logic [7:0] din, dout;
  logic [3:0] len;

  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_carry, b_busy;
  logic [3:0] b_in, b_out, b_len;

  int tests_run = 0;
  int fails = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  step_seq #(.width(W), .step(STEP), .lenw(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .len(len), .out_valid(out_valid), .out_ready(out_ready), .out(dout),
    .last(last), .carry(carry), .busy(busy)
  );

  step_seq #(.width(4), .step(7), .lenw(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
    .len(b_len), .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .last(b_last), .carry(b_carry), .busy(b_busy)
  );

  // Reference model: push every beat the request should produce.
  task automatic push_model(input logic [7:0] v, input logic [3:0] l);
    logic [7:0] cur;
    logic [8:0] t;
    beat_t e;
    cur = v;
    for (int i = 0; i < int'(l); i++) begin
      t = {1'b0, cur} + 9'(STEP);
      e.v = t[7:0];
      e.c = t[8];
      e.l = (i == int'(l) - 1);
      q.push_back(e);
      cur = t[7:0];
    end
  endtask

  // Drives one accept; returns at the negedge where the first beat should be visible.
  task automatic start(input logic [7:0] v, input logic [3:0] l, input string name);
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1;
    din = v;
    len = l;
    push_model(v, l);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== (l != 0) || busy !== (l != 0) || in_ready !== (l == 0)) begin
      fails++;
      $display("FAIL %s_latency: got valid=%b busy=%b in_ready=%b want valid=%b busy=%b in_ready=%b",
               name, out_valid, busy, in_ready, l != 0, l != 0, l == 0);
    end
  endtask

  // Called at a negedge; compares each cycle, optionally stalls 4 cycles on beat stall_at.
  task automatic drain(input int n, input int stall_at, input string name);
    int got = 0;
    int stalls = 0;
    int cyc = 0;
    beat_t e;
    while (got < n && cyc < 100) begin
      if (q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL %s_queue: got empty scoreboard want %0d more beats", name, n - got);
        break;
      end
      e = q[0];
      tests_run++;
      if (out_valid !== 1'b1 || dout !== e.v || carry !== e.c || last !== e.l) begin
        fails++;
        $display("FAIL %s_beat%0d: got valid=%b out=%h carry=%b last=%b want valid=1 out=%h carry=%b last=%b",
                 name, got, out_valid, dout, carry, last, e.v, e.c, e.l);
      end
      if (got == stall_at && stalls < 4) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
        e = q.pop_front();
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < n) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: got %0d beats want %0d", name, got, n);
    end
  endtask

  task automatic check_idle(input logic [7:0] final_v, input string name);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 ||
        carry !== 1'b0 || dout !== final_v) begin
      fails++;
      $display("FAIL %s_idle: got in_ready=%b valid=%b busy=%b last=%b carry=%b out=%h want 1 0 0 0 0 %h",
               name, in_ready, out_valid, busy, last, carry, dout, final_v);
    end
  endtask

  task automatic check_reset_vals(input string name);
    tests_run++;
    if (dout !== 8'h00 || out_valid !== 1'b0 || last !== 1'b0 || carry !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: got out=%h valid=%b last=%b carry=%b busy=%b in_ready=%b want 00 0 0 0 0 1",
               name, dout, out_valid, last, carry, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    din = 8'h55;
    len = 4'd3;
    out_ready = 1'b1;
    b_in_valid = 1'b0;
    b_in = '0;
    b_len = '0;
    b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start(8'd10, 4'd3, "basic");
    drain(3, -1, "basic");
    check_idle(8'd19, "basic");
  endtask

  task automatic test_wrap();
    start(8'hFE, 4'd2, "wrap");
    drain(2, -1, "wrap");
    check_idle(8'h04, "wrap");
  endtask

  task automatic test_backpressure();
    start(8'd10, 4'd3, "bp");
    drain(3, 1, "bp");
    check_idle(8'd19, "bp");
  endtask

  task automatic test_len_zero();
    start(8'd7, 4'd0, "len0");
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL len0_quiet: got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    start(8'd5, 4'd1, "len1");
    drain(1, -1, "len1");
    check_idle(8'd8, "len1");
  endtask

  task automatic test_reset_mid();
    start(8'd0, 4'd15, "rstmid");
    drain(2, -1, "rstmid");
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("rstmid_reset");
    rst_n = 1'b1;
    q.delete();
    start(8'd20, 4'd1, "rstmid_new");
    drain(1, -1, "rstmid_new");
    check_idle(8'd23, "rstmid_new");
  endtask

  // in_valid held high through RUN must be ignored, then accepted right after the last beat.
  task automatic test_back_to_back();
    start(8'd100, 4'd2, "b2b");
    in_valid = 1'b1;
    din = 8'd50;
    len = 4'd3;
    drain(2, -1, "b2b_first");
    check_idle(8'd106, "b2b_bubble");
    push_model(8'd50, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    drain(3, -1, "b2b_second");
    check_idle(8'd59, "b2b_second");
  endtask

  task automatic test_override();
    logic [3:0] cur;
    logic [4:0] t;
    @(negedge clk);
    tests_run++;
    if (b_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ovr_in_ready: got %b want 1", b_in_ready);
    end
    b_in_valid = 1'b1;
    b_in = 4'hA;
    b_len = 4'd3;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    cur = 4'hA;
    for (int i = 0; i < 3; i++) begin
      t = {1'b0, cur} + 5'd7;
      tests_run++;
      if (b_out_valid !== 1'b1 || b_out !== t[3:0] || b_carry !== t[4] || b_last !== (i == 2)) begin
        fails++;
        $display("FAIL ovr_beat%0d: got valid=%b out=%h carry=%b last=%b want valid=1 out=%h carry=%b last=%b",
                 i, b_out_valid, b_out, b_carry, b_last, t[3:0], t[4], i == 2);
      end
      cur = t[3:0];
      @(negedge clk);
    end
    tests_run++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out !== 4'hF) begin
      fails++;
      $display("FAIL ovr_idle: got valid=%b in_ready=%b out=%h want 0 1 f", b_out_valid, b_in_ready, b_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    test_override();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/step_seq.md
# step_seq

Sequential stepping source that sits directly upstream of the `inc` stage. It accepts a start value and a beat count over a valid/ready handshake. It then emits the arithmetic sequence start+step, start+2·step, … one beat per downstream handshake, modulo 2^width. It uses the same `width`/`step` parameterisation as `inc`, so a chain of `step_seq` followed by `inc` can be instantiated with matching overrides.

## Interface
Parameters:
- `width`, 8, data width of `in`/`out`.
- `step`, 1, increment per beat, truncated to `width` bits.
- `lenw`, 4, width of the `len` beat-count port.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `in_valid`  input  1  upstream start value/count present.
- `in_ready`  output  1  block can accept a start value.
- `in`  input  width  start value.
- `len`  input  lenw  number of beats to emit, 0..2^lenw−1.
- `out_valid`  output  1  `out` holds a valid beat.
- `out_ready`  input  1  downstream accepts the beat.
- `out`  output  width  current sequence value.
- `last`  output  1  current beat is the final one of the sequence.
- `carry`  output  1  the addition producing `out` overflowed `width` bits.
- `busy`  output  1  sequence in progress, equal to the RUN state.

## Operation
- The block has two states, IDLE and RUN. `in_ready` is 1 only in IDLE, and `busy` equals the RUN state.
- **IDLE**, on accept (`in_valid && in_ready`):
  - `len`==0: the input is consumed, no beat is emitted, and the block stays in IDLE.
  - `len`≥1: `out` <= `in`+`step` (low `width` bits), `carry` <= bit `width` of that sum, `rem` <= `len`, `out_valid` <= 1, `last` <= (`len`==1), next state RUN.
- **RUN**:
  - `out`, `carry` and `last` are held stable while `out_valid && !out_ready`.
  - On an output handshake with `rem`>1: `out` <= `out`+`step`, `carry` <= overflow of that sum, `rem` <= `rem`−1, `last` <= (`rem`==2).
  - On an output handshake with `rem`==1, i.e. `last`=1: `out_valid` <= 0, `last` <= 0, `carry` <= 0, next state IDLE. `out` keeps its final value.
- `in_valid` is ignored in RUN, so no accept is possible there.
- Arithmetic:
  - Each sum is computed at `width`+1 bits; `out` takes the low `width` bits and `carry` takes the MSB.
  - Wrap-around is modulo 2^width with no saturation.
  - `step`=0 is legal; it produces `len` beats of value `in` with `carry`=0.
- Internal counter `rem` is `lenw` bits wide and is never observed directly.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - Outputs: `out`=0, `out_valid`=0, `last`=0, `carry`=0, `busy`=0, `in_ready`=1 (one cycle after reset asserts).
  - `rem` is cleared and the state returns to IDLE.
  - A reset mid-sequence discards the remaining beats, and reset overrides any handshake in the same cycle.
- Latency: a start value accepted at edge N gives `out_valid`=1 with the first beat in the cycle after edge N.
- Throughput: with `out_ready` held at 1, the block emits one beat per cycle.
- Back-to-back sequences:
  - After the final handshake at edge M, the block is in IDLE during the cycle after M, so a new accept occurs at edge M+1 at the earliest.
  - The first beat of the new sequence appears after edge M+1, giving a one-cycle bubble between sequences.
- `in_ready` and `busy` are purely state-decoded, with no combinational path from `in_valid` or `out_ready`.
- `out_valid` never drops without a handshake, except on reset.

## Test plan
- Basic sequence (`width`=8, `step`=3): `in`=10, `len`=3, `out_ready`=1 → `out` = 13, 16, 19 on consecutive cycles; `last`=1 only on 19; `in_ready`=1 again one cycle after the 19 handshake.
- Wrap (`step`=3): `in`=0xFE, `len`=2 → `out`=0x01 with `carry`=1, then `out`=0x04 with `carry`=0.
- Backpressure: during the `in`=10 sequence, hold `out_ready`=0 for 4 cycles on the second beat → `out` stays 16, `out_valid`=1 and `last`=0 throughout; the sequence resumes with 19 and finishes normally.
- `len`=0 accept → no `out_valid` pulse; `in_ready` stays 1; a following `in`=5, `len`=1 gives a single beat `out`=8 with `last`=1.
- Reset mid-op: `in`=0, `len`=15, reset asserted after 2 beats → the next cycle shows all outputs at reset values and `in_ready`=1; a new start of `in`=20, `len`=1 gives `out`=23.
- Override `width`=4, `step`=7: `in`=0xA, `len`=3 → `out` = 0x1 (`carry`=1), 0x8 (`carry`=0), 0xF (`carry`=0, `last`=1).
